// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter with packet lock feeding one registered
// ready/valid output channel shared by num_req_p requesters.
module stream_rr_arbiter #(
  parameter int width_p = 8,
  parameter int num_req_p = 2,
  localparam int id_w = $clog2(num_req_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_req_p*width_p-1:0] data_i,
  input  logic [num_req_p-1:0]         valid_i,
  input  logic [num_req_p-1:0]         last_i,
  output logic [num_req_p-1:0]         ready_o,
  output logic                         valid_o,
  output logic [width_p-1:0]           data_o,
  output logic [id_w-1:0]              src_o,
  output logic                         last_o,
  input  logic                         ready_i
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e state_r, state_n;

  logic [id_w-1:0]    ptr_r, ptr_n;
  logic [id_w-1:0]    grant_r, grant_n;
  logic [id_w-1:0]    sel, sel_inc, cand;
  logic [id_w:0]      wide;
  logic               sel_ok, sel_last;
  logic               space, accept;
  logic [width_p-1:0] sel_data;

  logic               full_r;
  logic [width_p-1:0] data_r;
  logic [id_w-1:0]    src_r;
  logic               last_r;

  assign space = !full_r || ready_i;

  // Reverse scan so the smallest offset from ptr_r wins.
  always_comb begin
    sel    = grant_r;
    sel_ok = 1'b0;
    wide   = '0;
    cand   = '0;
    if (state_r == LOCKED) begin
      sel_ok = 1'b1;
    end else begin
      for (int i = num_req_p - 1; i >= 0; i--) begin
        wide = {1'b0, ptr_r} + (id_w+1)'(i);
        if (wide >= (id_w+1)'(num_req_p))
          wide = wide - (id_w+1)'(num_req_p);
        cand = wide[id_w-1:0];
        if (valid_i[cand]) begin
          sel    = cand;
          sel_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (sel == id_w'(k))
        sel_data = data_i[k*width_p +: width_p];
    end
  end

  assign sel_last = last_i[sel];
  assign accept   = sel_ok && valid_i[sel] && space;
  assign sel_inc  = (sel == id_w'(num_req_p - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    ready_o = '0;
    if (sel_ok)
      ready_o[sel] = space;
  end

  always_comb begin
    state_n = state_r;
    ptr_n   = ptr_r;
    grant_n = grant_r;
    if (accept) begin
      unique case (state_r)
        IDLE: begin
          if (sel_last) begin
            ptr_n = sel_inc;
          end else begin
            state_n = LOCKED;
            grant_n = sel;
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state_n = IDLE;
            ptr_n   = sel_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      grant_r <= '0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      grant_r <= grant_n;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_r <= 1'b0;
      data_r <= '0;
      src_r  <= '0;
      last_r <= 1'b0;
    end else if (accept) begin
      full_r <= 1'b1;
      data_r <= sel_data;
      src_r  <= sel;
      last_r <= sel_last;
    end else if (ready_i) begin
      full_r <= 1'b0;
    end
  end

  assign valid_o = full_r;
  assign data_o  = data_r;
  assign src_o   = src_r;
  assign last_o  = last_r;

endmodule
